// File: rtl/adder_word_sequencer_if.sv
// ============================================================================
//  Module   : adder_word_sequencer_if
//  Purpose  : Operand and result streams for the multi-precision add sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_word_sequencer_if #(
    parameter int WORD_W = 1024
) ();
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_a;
    logic [WORD_W-1:0] s_b;
    logic              s_cin;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_sum;
    logic              m_last;
    logic              m_cout;

    modport master (
        output s_valid, s_a, s_b, s_cin, m_ready,
        input  s_ready, m_valid, m_sum, m_last, m_cout
    );

    modport slave (
        input  s_valid, s_a, s_b, s_cin, m_ready,
        output s_ready, m_valid, m_sum, m_last, m_cout
    );
endinterface

`default_nettype wire

// File: rtl/adder_word_sequencer.sv
// ============================================================================
//  Module   : adder_word_sequencer
//  Purpose  : Streams NWORDS word pairs through an external registered adder,
//             chains the carry and buffers results in a 2-entry output queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_word_sequencer #(
    parameter int WORD_W = 1024,
    parameter int NWORDS = 4
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    adder_word_sequencer_if.slave  bus,
    output logic [WORD_W-1:0]      add_a,
    output logic [WORD_W-1:0]      add_b,
    output logic                   add_cin,
    input  wire logic [WORD_W-1:0] add_sum,
    input  wire logic              add_cout,
    output logic                   busy
);

    localparam int                IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              r_inflight;
    logic              r_tag_last;
    logic              r_carry;

    logic [WORD_W-1:0] r_q_sum [2];
    logic [1:0]        r_q_last;
    logic [1:0]        r_q_cout;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;

    logic              w_issue;
    logic              w_pop;
    logic              w_m_valid;
    logic              w_is_last;
    logic [2:0]        w_pending;

    assign w_m_valid = (r_occ != 2'd0);
    assign w_pop     = w_m_valid && bus.m_ready;

    // Count results already owed to the queue so a word is only issued when
    // its result is guaranteed a slot one cycle later.
    assign w_pending   = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign bus.s_ready = resetn && (w_pending < 3'd2);
    assign w_issue     = bus.s_valid && bus.s_ready;

    assign add_a   = bus.s_a;
    assign add_b   = bus.s_b;
    assign add_cin = (r_state == ST_IDLE) ? bus.s_cin
                                          : (r_inflight ? add_cout : r_carry);
    assign busy    = (r_state == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_is_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (NWORDS == 1) begin
                    w_is_last = 1'b1;
                end else if (w_issue) begin
                    w_idx_nxt   = IDX_W'(1);
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_is_last = (r_idx == LAST_IDX);
                if (w_issue) begin
                    if (w_is_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_inflight <= 1'b0;
            r_tag_last <= 1'b0;
            r_carry    <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_inflight <= w_issue;
            r_tag_last <= w_issue && w_is_last;
            if (r_inflight) begin
                r_carry  <= add_cout;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Queue storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_q_sum[r_wr_ptr]  <= add_sum;
            r_q_last[r_wr_ptr] <= r_tag_last;
            r_q_cout[r_wr_ptr] <= r_tag_last && add_cout;
        end
    end

    assign bus.m_valid = w_m_valid;
    assign bus.m_sum   = w_m_valid ? r_q_sum[r_rd_ptr] : '0;
    assign bus.m_last  = w_m_valid && r_q_last[r_rd_ptr];
    assign bus.m_cout  = w_m_valid && r_q_cout[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_adder_word_sequencer.sv
// ============================================================================
//  Module   : tb_adder_word_sequencer
//  Purpose  : Directed checks of the add sequencer with registered adder models.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_word_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 8-bit, 4-word instance ----------------
    adder_word_sequencer_if #(.WORD_W(8)) bus8 ();
    logic [7:0] a8_a, a8_b, a8_sum;
    logic       a8_cin, a8_cout, busy8;

    adder_word_sequencer #(.WORD_W(8), .NWORDS(4)) dut8 (
        .clk(clk), .resetn(resetn), .bus(bus8),
        .add_a(a8_a), .add_b(a8_b), .add_cin(a8_cin),
        .add_sum(a8_sum), .add_cout(a8_cout), .busy(busy8)
    );

    always @(posedge clk) begin
        if (!resetn) {a8_cout, a8_sum} <= '0;
        else         {a8_cout, a8_sum} <= {1'b0, a8_a} + {1'b0, a8_b} + {8'b0, a8_cin};
    end

    // ---------------- 1024-bit, 1-word instance ----------------
    adder_word_sequencer_if #(.WORD_W(1024)) bus1k ();
    logic [1023:0] ak_a, ak_b, ak_sum;
    logic          ak_cin, ak_cout, busy1k;

    adder_word_sequencer #(.WORD_W(1024), .NWORDS(1)) dut1k (
        .clk(clk), .resetn(resetn), .bus(bus1k),
        .add_a(ak_a), .add_b(ak_b), .add_cin(ak_cin),
        .add_sum(ak_sum), .add_cout(ak_cout), .busy(busy1k)
    );

    always @(posedge clk) begin
        if (!resetn) {ak_cout, ak_sum} <= '0;
        else         {ak_cout, ak_sum} <= {1'b0, ak_a} + {1'b0, ak_b} + {1024'b0, ak_cin};
    end

    // Result monitors: a record is taken when the transfer will happen at the next edge.
    typedef struct packed { logic cout; logic last; logic [7:0] sum; logic [31:0] c; } rec8_t;
    rec8_t         mon8_q[$];
    logic [1025:0] mon1k_q[$];

    always @(negedge clk) begin
        if (resetn && bus8.m_valid && bus8.m_ready)
            mon8_q.push_back({bus8.m_cout, bus8.m_last, bus8.m_sum, cyc});
        if (resetn && bus1k.m_valid && bus1k.m_ready)
            mon1k_q.push_back({bus1k.m_cout, bus1k.m_last, bus1k.m_sum});
    end

    // Sends nw words; s_cin on words > 0 is inverted to prove it is ignored.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input int nw, input int gap_at, input int gap_len);
        int n;
        for (int k = 0; k < nw; k++) begin
            bus8.s_valid = 1'b1;
            bus8.s_a     = a[8*k +: 8];
            bus8.s_b     = b[8*k +: 8];
            bus8.s_cin   = (k == 0) ? cin : ~cin;
            n = 0;
            @(negedge clk);
            while (bus8.s_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                tests_run++; tests_failed++;
                $display("FAIL send_timeout word=%0d s_ready=%b required 1", k, bus8.s_ready);
            end
            @(posedge clk); #1;
            if (k == gap_at) begin
                bus8.s_valid = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        bus8.s_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int c = 0;
        while (mon8_q.size() < n && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (mon8_q.size() < n) begin
            tests_run++; tests_failed++;
            $display("FAIL result_timeout got %0d words required %0d", mon8_q.size(), n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus8.s_ready, bus8.m_valid, bus8.m_sum, bus8.m_last, bus8.m_cout, busy8} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got s_ready=%b m_valid=%b m_sum=%h m_last=%b m_cout=%b busy=%b required all 0",
                     bus8.s_ready, bus8.m_valid, bus8.m_sum, bus8.m_last, bus8.m_cout, busy8);
        end
        resetn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus8.s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready got %b required 1", bus8.s_ready);
        end
    endtask

    task automatic test_carry_ripple();
        mon8_q.delete();
        @(posedge clk); #1;
        send_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4, -1, 0);
        wait_results(4);
        for (int i = 0; i < 4 && i < mon8_q.size(); i++) begin
            tests_run++;
            if ({mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum} !== {(i == 3), (i == 3), 8'h00}) begin
                tests_failed++;
                $display("FAIL ripple_w%0d got cout=%b last=%b sum=%h required cout=%b last=%b sum=00",
                         i, mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum, (i == 3), (i == 3));
            end
            if (i > 0) begin
                tests_run++;
                if (mon8_q[i].c !== mon8_q[i-1].c + 1) begin
                    tests_failed++;
                    $display("FAIL ripple_spacing_w%0d got cycle %0d required %0d",
                             i, mon8_q[i].c, mon8_q[i-1].c + 1);
                end
            end
        end
    endtask

    task automatic test_bubble_hold();
        mon8_q.delete();
        send_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4, 1, 3);
        wait_results(4);
        for (int i = 0; i < 4 && i < mon8_q.size(); i++) begin
            tests_run++;
            if ({mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum} !== {(i == 3), (i == 3), 8'h00}) begin
                tests_failed++;
                $display("FAIL bubble_w%0d got cout=%b last=%b sum=%h required cout=%b last=%b sum=00",
                         i, mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum, (i == 3), (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_sum [4];
        exp_sum[0] = 8'h05; exp_sum[1] = 8'h06; exp_sum[2] = 8'h06; exp_sum[3] = 8'h06;
        mon8_q.delete();
        fork
            send_op(32'h4030_2010, 32'hC5D5_E5F5, 1'b0, 4, -1, 0);
            begin
                bus8.m_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                tests_run++;
                if ({bus8.s_ready, bus8.m_valid} !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL stall_ready got s_ready=%b m_valid=%b required s_ready=0 m_valid=1",
                             bus8.s_ready, bus8.m_valid);
                end
                @(posedge clk); #1;
                bus8.m_ready = 1'b1;
            end
        join
        wait_results(4);
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (mon8_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL stall_count got %0d words required 4", mon8_q.size());
        end
        for (int i = 0; i < 4 && i < mon8_q.size(); i++) begin
            tests_run++;
            if ({mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum} !== {(i == 3), (i == 3), exp_sum[i]}) begin
                tests_failed++;
                $display("FAIL stall_w%0d got cout=%b last=%b sum=%h required cout=%b last=%b sum=%h",
                         i, mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum, (i == 3), (i == 3), exp_sum[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        mon8_q.delete();
        send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4, -1, 0);
        send_op(32'h0101_0101, 32'h0101_0101, 1'b0, 4, -1, 0);
        wait_results(8);
        for (int i = 0; i < 8 && i < mon8_q.size(); i++) begin
            tests_run++;
            if ({mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum} !==
                {(i == 3), (i == 3 || i == 7), (i < 4) ? 8'h00 : 8'h02}) begin
                tests_failed++;
                $display("FAIL b2b_w%0d got cout=%b last=%b sum=%h required cout=%b last=%b sum=%h",
                         i, mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum,
                         (i == 3), (i == 3 || i == 7), (i < 4) ? 8'h00 : 8'h02);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp_sum [4];
        exp_sum[0] = 8'h13; exp_sum[1] = 8'h35; exp_sum[2] = 8'h57; exp_sum[3] = 8'h79;
        send_op(32'h7856_3412, 32'h0101_0101, 1'b0, 2, -1, 0);
        @(negedge clk);
        tests_run++;
        if (busy8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_busy got %b required 1", busy8);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({bus8.s_ready, bus8.m_valid, bus8.m_sum, bus8.m_last, bus8.m_cout, busy8} !== 13'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs got s_ready=%b m_valid=%b m_sum=%h m_last=%b m_cout=%b busy=%b required all 0",
                     bus8.s_ready, bus8.m_valid, bus8.m_sum, bus8.m_last, bus8.m_cout, busy8);
        end
        resetn = 1'b1;
        mon8_q.delete();
        @(negedge clk);
        tests_run++;
        if (bus8.m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_queue_empty got m_valid=%b required 0", bus8.m_valid);
        end
        mon8_q.delete();
        @(posedge clk); #1;
        send_op(32'h7856_3412, 32'h0101_0101, 1'b0, 4, -1, 0);
        wait_results(4);
        for (int i = 0; i < 4 && i < mon8_q.size(); i++) begin
            tests_run++;
            if ({mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum} !== {1'b0, (i == 3), exp_sum[i]}) begin
                tests_failed++;
                $display("FAIL postreset_w%0d got cout=%b last=%b sum=%h required cout=0 last=%b sum=%h",
                         i, mon8_q[i].cout, mon8_q[i].last, mon8_q[i].sum, (i == 3), exp_sum[i]);
            end
        end
    endtask

    task automatic test_wide_single_word();
        logic [1025:0] exp_q[$];
        logic [1023:0] a, b;
        logic          cin;
        logic [1024:0] full;
        int            n;
        mon1k_q.delete();
        for (int op = 0; op < 1000; op++) begin
            for (int j = 0; j < 32; j++) begin
                a[32*j +: 32] = $urandom();
                b[32*j +: 32] = $urandom();
            end
            if (op == 0) begin
                a = '1; b = '0;
            end
            cin  = (op == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + {1024'b0, cin};
            exp_q.push_back({full[1024], 1'b1, full[1023:0]});
            bus1k.s_valid = 1'b1;
            bus1k.s_a     = a;
            bus1k.s_b     = b;
            bus1k.s_cin   = cin;
            n = 0;
            @(negedge clk);
            while (bus1k.s_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                tests_run++; tests_failed++;
                $display("FAIL wide_send_timeout op=%0d s_ready=%b required 1", op, bus1k.s_ready);
            end
            @(posedge clk); #1;
        end
        bus1k.s_valid = 1'b0;
        n = 0;
        while (mon1k_q.size() < 1000 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        tests_run++;
        if (mon1k_q.size() !== 1000) begin
            tests_failed++;
            $display("FAIL wide_count got %0d results required 1000", mon1k_q.size());
        end
        for (int i = 0; i < 1000 && i < mon1k_q.size(); i++) begin
            tests_run++;
            if (mon1k_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL wide_op%0d got cout=%b last=%b sum_lo=%h required cout=%b last=%b sum_lo=%h",
                         i, mon1k_q[i][1025], mon1k_q[i][1024], mon1k_q[i][63:0],
                         exp_q[i][1025], exp_q[i][1024], exp_q[i][63:0]);
            end
        end
    endtask

    initial begin
        bus8.s_valid  = 1'b0; bus8.s_a  = '0; bus8.s_b  = '0; bus8.s_cin  = 1'b0; bus8.m_ready  = 1'b1;
        bus1k.s_valid = 1'b0; bus1k.s_a = '0; bus1k.s_b = '0; bus1k.s_cin = 1'b0; bus1k.m_ready = 1'b1;
        test_reset();
        test_carry_ripple();
        test_bubble_hold();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_wide_single_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d cycles required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
